// File: rtl/x_ramb16_s1_word_ctrl.sv
// Word-wide access controller for a 16K x 1 block RAM port.
// Each word is sent as WORD_W single-bit RAM accesses, LSB first. Read bits are
// gathered around the RAM's one-cycle registered read latency and returned on
// a valid/ready response channel. All outputs come straight from registers.
module x_ramb16_s1_word_ctrl #(
  parameter  int LOG2_WORD = 3,
  localparam int WORD_W    = 2**LOG2_WORD,
  localparam int WADDR_W   = 14 - LOG2_WORD
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic               REQ_WE,
  input  logic [WADDR_W-1:0] REQ_ADDR,
  input  logic [WORD_W-1:0]  REQ_WDATA,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [WORD_W-1:0]  RSP_RDATA,
  output logic [13:0]        RAM_ADDR,
  output logic               RAM_DI,
  output logic               RAM_EN,
  output logic               RAM_WE,
  input  logic               RAM_DO
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_RSP} state_t;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [WORD_W-1:0]  wdata;
  } req_t;

  localparam logic [LOG2_WORD-1:0] CNT_LAST = LOG2_WORD'(WORD_W - 1);

  state_t                r_state, w_state_nxt;
  logic [LOG2_WORD-1:0]  r_cnt, w_cnt_nxt;
  req_t                  r_req, w_req_nxt;
  logic [WORD_W-1:0]     r_rdata, w_rdata_nxt;
  logic                  r_req_ready, w_req_ready_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [13:0]           r_ram_addr, w_ram_addr_nxt;
  logic                  r_ram_di, w_ram_di_nxt;
  logic                  r_ram_en, w_ram_en_nxt;
  logic                  r_ram_we, w_ram_we_nxt;
  logic [LOG2_WORD-1:0]  w_cnt_inc, w_cnt_dec;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_cnt_dec = r_cnt - 1'b1;

  // State and every output register; reset drops the RAM port to idle at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_rdata     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_di    <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req       <= w_req_nxt;
      r_rdata     <= w_rdata_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_di    <= w_ram_di_nxt;
      r_ram_en    <= w_ram_en_nxt;
      r_ram_we    <= w_ram_we_nxt;
    end
  end

  // Next state and next register values; RAM enables default off, the RAM
  // address/data hold so the port only toggles when a bit is actually moved.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_req_nxt       = r_req;
    w_rdata_nxt     = r_rdata;
    w_req_ready_nxt = r_req_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_di_nxt    = r_ram_di;
    w_ram_en_nxt    = 1'b0;
    w_ram_we_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Ready rises on the first edge after reset release.
        w_req_ready_nxt = 1'b1;
        if (REQ_VALID && r_req_ready) begin
          w_req_nxt.addr  = REQ_ADDR;
          w_req_nxt.wdata = REQ_WDATA;
          w_cnt_nxt       = '0;
          w_req_ready_nxt = 1'b0;
          w_ram_en_nxt    = 1'b1;
          w_ram_addr_nxt  = {REQ_ADDR, {LOG2_WORD{1'b0}}};
          if (REQ_WE) begin
            w_state_nxt  = S_WR;
            w_ram_we_nxt = 1'b1;
            w_ram_di_nxt = REQ_WDATA[0];
          end else begin
            w_state_nxt  = S_RD;
          end
        end
      end
      S_WR: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt     = S_IDLE;
          w_req_ready_nxt = 1'b1;
        end else begin
          w_cnt_nxt      = w_cnt_inc;
          w_ram_en_nxt   = 1'b1;
          w_ram_we_nxt   = 1'b1;
          w_ram_addr_nxt = {r_req.addr, w_cnt_inc};
          w_ram_di_nxt   = r_req.wdata[w_cnt_inc];
        end
      end
      S_RD: begin
        // RAM_DO now shows the bit addressed in the previous cycle.
        if (r_cnt != '0) w_rdata_nxt[w_cnt_dec] = RAM_DO;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt    = S_DRAIN;
        end else begin
          w_cnt_nxt      = w_cnt_inc;
          w_ram_en_nxt   = 1'b1;
          w_ram_addr_nxt = {r_req.addr, w_cnt_inc};
        end
      end
      S_DRAIN: begin
        w_rdata_nxt[WORD_W-1] = RAM_DO;
        w_state_nxt           = S_RSP;
        w_rsp_valid_nxt       = 1'b1;
      end
      S_RSP: begin
        if (RSP_READY) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_req_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_rsp_valid_nxt = 1'b0;
        w_req_ready_nxt = 1'b0;
      end
    endcase
  end

  assign REQ_READY = r_req_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rdata;
  assign RAM_ADDR  = r_ram_addr;
  assign RAM_DI    = r_ram_di;
  assign RAM_EN    = r_ram_en;
  assign RAM_WE    = r_ram_we;

endmodule

// File: tb/tb_x_ramb16_s1_word_ctrl.sv
// Bench for the word controller: a 16K x 1 registered-read RAM, a
// transaction-level model of the expected port timeline, and directed tests.
module tb_x_ramb16_s1_word_ctrl;
  localparam int LW = 3;
  localparam int W  = 8;
  localparam int AW = 14 - LW;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic          REQ_WE = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [W-1:0]  REQ_WDATA = '0;
  logic          RSP_VALID;
  logic          RSP_READY = 1'b0;
  logic [W-1:0]  RSP_RDATA;
  logic [13:0]   RAM_ADDR;
  logic          RAM_DI, RAM_EN, RAM_WE;
  logic          RAM_DO = 1'b0;

  x_ramb16_s1_word_ctrl #(.LOG2_WORD(LW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_EN(RAM_EN), .RAM_WE(RAM_WE),
    .RAM_DO(RAM_DO)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // 16K x 1 block RAM with registered read
  bit ram [16384];
  always @(posedge CLK) begin
    if (RAM_EN) begin
      if (RAM_WE) ram[RAM_ADDR] <= RAM_DI;
      else        RAM_DO <= ram[RAM_ADDR];
    end
  end

  // Transaction model: m_k counts edges since the accept edge.
  bit            exp_mem [16384];
  bit            m_up, m_rsp;
  int            m_op, m_k, m_a;
  logic [W-1:0]  m_d, m_rdata, m_last_rdata;
  int            m_last_addr;
  logic          m_last_di;

  function automatic logic [W-1:0] mem_word(input int a);
    logic [W-1:0] w;
    for (int b = 0; b < W; b++) w[b] = exp_mem[a*W+b];
    return w;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      // a write cut short keeps only the bits already committed
      if (m_op == 1) for (int b = 0; b < W; b++) if (b < m_k) exp_mem[m_a*W+b] <= m_d[b];
      m_up <= 1'b0; m_op <= 0; m_k <= 0; m_rsp <= 1'b0;
      m_last_addr <= 0; m_last_di <= 1'b0; m_last_rdata <= '0; m_rdata <= '0;
    end else begin
      m_up <= 1'b1;
      if (m_up && m_op == 0 && !m_rsp && REQ_VALID) begin
        m_op <= REQ_WE ? 1 : 2;
        m_a <= int'(REQ_ADDR); m_d <= REQ_WDATA; m_k <= 0;
        m_last_addr <= int'(REQ_ADDR) * W;
        if (REQ_WE) m_last_di <= REQ_WDATA[0];
      end else if (m_op != 0) begin
        m_k <= m_k + 1;
        if (m_op == 1 && m_k == W-1) begin
          for (int b = 0; b < W; b++) exp_mem[m_a*W+b] <= m_d[b];
          m_op <= 0;
        end else if (m_op == 2 && m_k == W) begin
          m_op <= 0; m_rsp <= 1'b1;
          m_rdata <= mem_word(m_a); m_last_rdata <= mem_word(m_a);
        end else if (m_k + 1 < W) begin
          m_last_addr <= m_a*W + m_k + 1;
          if (m_op == 1) m_last_di <= m_d[m_k+1];
        end
      end else if (m_rsp && RSP_READY) begin
        m_rsp <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    automatic bit en = (m_op != 0) && (m_k < W);
    chk("cmp_req_ready", REQ_READY, int'(m_up && m_op == 0 && !m_rsp));
    chk("cmp_ram_en", RAM_EN, int'(en));
    chk("cmp_ram_we", RAM_WE, int'(en && m_op == 1));
    chk("cmp_ram_addr", int'(RAM_ADDR), m_last_addr);
    chk("cmp_ram_di", RAM_DI, m_last_di);
    chk("cmp_rsp_valid", RSP_VALID, m_rsp);
    if (m_rsp) chk("cmp_rsp_rdata", RSP_RDATA, m_rdata);
    else if (m_op != 2) chk("cmp_rdata_hold", RSP_RDATA, m_last_rdata);
  end

  int acc_cyc;

  task automatic wait_ready();
    int n = 0;
    while (!REQ_READY && n < 60) begin @(negedge CLK); n++; end
    if (!REQ_READY) chk("req_ready_timeout", 0, 1);
  endtask

  // Present a request; returns 1ns after the accept edge.
  task automatic send(input logic we, input int a, input logic [W-1:0] d);
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = AW'(a); REQ_WDATA = d;
    wait_ready();
    @(posedge CLK); #1;
    acc_cyc = cyc;
    REQ_VALID = 1'b0;
  endtask

  // Wait for the response, hold off RSP_READY for 'hold' cycles, then take it.
  task automatic get_rsp(input int hold, input logic [W-1:0] exp_d,
                         output logic [W-1:0] data, output int lat);
    int n = 0;
    int we_seen = 0;
    lat = 0; data = '0;
    @(negedge CLK);
    while (!RSP_VALID && n < 40) begin
      if (RAM_WE) we_seen++;
      @(negedge CLK); n++;
    end
    chk("rd_no_ram_we", we_seen, 0);
    if (!RSP_VALID) begin chk("rsp_timeout", 0, 1); return; end
    lat = cyc - acc_cyc + 1;
    data = RSP_RDATA;
    for (int i = 0; i < hold; i++) begin
      chk("bp_rsp_valid", RSP_VALID, 1);
      chk("bp_rsp_rdata", RSP_RDATA, exp_d);
      chk("bp_req_ready", REQ_READY, 0);
      @(negedge CLK);
    end
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
  endtask

  initial begin
    int di_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    logic [W-1:0] d;
    int lat, a1, a2;
    logic [7:0] b8;

    // reset state
    #1 RST = 1'b1;
    #2;
    chk("rst_req_ready", REQ_READY, 0);
    chk("rst_ram_en", RAM_EN, 0);
    chk("rst_ram_addr", int'(RAM_ADDR), 0);
    chk("rst_rsp_rdata", RSP_RDATA, 0);
    #19 RST = 1'b0;
    @(negedge CLK);
    chk("rel_req_ready", REQ_READY, 1);
    chk("rel_ram_en", RAM_EN, 0);

    // write 0xA5 to word 3: bits go to 24..31, LSB first
    send(1'b1, 3, 8'hA5);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("wr_ram_addr", int'(RAM_ADDR), 24 + k);
      chk("wr_ram_di", RAM_DI, di_a5[k]);
      chk("wr_ram_we", RAM_WE, 1);
    end
    @(negedge CLK);
    chk("wr_end_we", RAM_WE, 0);
    chk("wr_end_ready", REQ_READY, 1);

    // read back word 3
    send(1'b0, 3, 8'h00);
    get_rsp(0, 8'hA5, d, lat);
    chk("rd_latency", lat, 10);
    chk("rd_data_a5", d, 8'hA5);

    // backpressure for 5 cycles
    send(1'b0, 3, 8'h00);
    get_rsp(5, 8'hA5, d, lat);
    chk("bp_data", d, 8'hA5);
    @(negedge CLK);
    chk("bp_ready_after", REQ_READY, 1);

    // top boundary word 2047 -> bits 16376..16383
    send(1'b1, 2047, 8'hFF);
    @(negedge CLK);
    chk("top_first_addr", int'(RAM_ADDR), 16376);
    repeat (7) @(negedge CLK);
    chk("top_last_addr", int'(RAM_ADDR), 16383);
    send(1'b0, 2047, 8'h00);
    get_rsp(0, 8'hFF, d, lat);
    chk("top_rd_ff", d, 8'hFF);
    send(1'b0, 2046, 8'h00);
    get_rsp(0, 8'h00, d, lat);
    chk("below_top_rd", d, 8'h00);

    // abort a write of 0xFF to pre-cleared word 0 during its 4th bit
    send(1'b1, 0, 8'h00);
    send(1'b1, 0, 8'hFF);
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("abort_ram_en", RAM_EN, 0);
    chk("abort_ram_we", RAM_WE, 0);
    chk("abort_ram_addr", int'(RAM_ADDR), 0);
    chk("abort_ram_di", RAM_DI, 0);
    chk("abort_req_ready", REQ_READY, 0);
    chk("abort_rsp_valid", RSP_VALID, 0);
    repeat (3) begin @(negedge CLK); chk("abort_en_low", RAM_EN, 0); end
    for (int b = 0; b < 8; b++) b8[b] = ram[b];
    chk("abort_ram_bits", b8, 8'h07);
    #2 RST = 1'b0;
    @(negedge CLK);
    chk("abort_rel_ready", REQ_READY, 1);
    chk("abort_rel_en", RAM_EN, 0);
    send(1'b0, 0, 8'h00);
    get_rsp(0, 8'h07, d, lat);
    chk("abort_readback", d, 8'h07);

    // back-to-back writes with REQ_VALID held
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = AW'(10); REQ_WDATA = 8'h3C;
    wait_ready();
    @(posedge CLK); #1;
    a1 = cyc; REQ_ADDR = AW'(11); REQ_WDATA = 8'hC3;
    @(negedge CLK);
    wait_ready();
    @(posedge CLK); #1;
    a2 = cyc; REQ_VALID = 1'b0;
    chk("b2b_spacing", a2 - a1, 9);
    send(1'b0, 10, 8'h00);
    get_rsp(0, 8'h3C, d, lat);
    chk("b2b_rd10", d, 8'h3C);
    send(1'b0, 11, 8'h00);
    get_rsp(0, 8'hC3, d, lat);
    chk("b2b_rd11", d, 8'hC3);

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
